jtag_shift_engine: RTL and testbench

JTAG_SHIFT_ENGINE -- requirements
Module: jtag_shift_engine

---
 rtl/jtag_shift_engine.sv | 219 +++++++++++++++++++++
 tb/tb_jtag_shift_engine.sv | 472 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_shift_engine.sv
// JTAG shift engine: clocks up to 8 TDI/TMS bits out on a generated TCK and
// captures TDO, with level-buffer enables, TRST/SRST drive and status reporting.
module jtag_shift_engine #(
  parameter int unsigned HALF = 4
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       CMD_VALID,
  output logic       CMD_READY,
  input  logic [7:0] CMD_TDI,
  input  logic [2:0] CMD_LEN,
  input  logic       CMD_TMS_LAST,
  input  logic       CMD_READ,
  output logic       RSP_VALID,
  input  logic       RSP_READY,
  output logic [7:0] RSP_TDO,
  input  logic       CTRL_WE,
  input  logic [2:0] CTRL_DATA,
  output logic [2:0] STAT,
  output logic       TCK_OUT,
  output logic       TMS_OUT,
  output logic       TDI_OUT,
  output logic       JTAG_OE_N,
  output logic       TRST_N_OE_N,
  output logic       TRST_N_OUT,
  output logic       SRST_N_OE_N,
  output logic       SRST_N_OUT,
  input  logic       TDO_IN,
  input  logic       SRST_N_IN,
  input  logic       VREF_N_IN
);

  typedef enum logic [1:0] {S_IDLE, S_LOW, S_HIGH, S_RESP} state_t;

  localparam logic [7:0] LP_HALF_M1 = 8'(HALF - 1);

  state_t     r_state, w_state_nxt;
  logic [7:0] r_cnt, w_cnt_nxt;
  logic [2:0] r_idx, w_idx_nxt;
  logic [7:0] r_tdi, w_tdi_nxt;
  logic [2:0] r_len, w_len_nxt;
  logic       r_tms_last, w_tms_last_nxt;
  logic       r_read, w_read_nxt;
  logic [7:0] r_cap, w_cap_nxt;
  logic       r_tck, w_tck_nxt;
  logic       r_tms, w_tms_nxt;
  logic       r_tdi_out, w_tdi_out_nxt;
  logic       r_oe_n, w_oe_n_nxt;
  logic       r_ready, w_ready_nxt;
  logic       r_rsp_valid, w_rsp_valid_nxt;
  logic [7:0] r_rsp_tdo, w_rsp_tdo_nxt;
  logic [2:0] r_ctrl, w_ctrl_nxt;
  logic       r_abort, w_abort_nxt;

  logic [1:0] r_tdo_s, r_srst_s, r_vref_s;
  logic       w_vref_ok, w_run_ok, w_accept;
  logic [2:0] w_idx_inc;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_tdo_s  <= 2'b00;
      r_srst_s <= 2'b00;
      r_vref_s <= 2'b00;
    end else begin
      r_tdo_s  <= {r_tdo_s[0], TDO_IN};
      r_srst_s <= {r_srst_s[0], SRST_N_IN};
      r_vref_s <= {r_vref_s[0], VREF_N_IN};
    end
  end

  assign w_vref_ok = ~r_vref_s[1];
  assign w_run_ok  = r_ctrl[0] & w_vref_ok;
  assign w_accept  = CMD_VALID & r_ready;
  assign w_idx_inc = r_idx + 3'd1;

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_idx_nxt       = r_idx;
    w_tdi_nxt       = r_tdi;
    w_len_nxt       = r_len;
    w_tms_last_nxt  = r_tms_last;
    w_read_nxt      = r_read;
    w_cap_nxt       = r_cap;
    w_tck_nxt       = r_tck;
    w_tms_nxt       = r_tms;
    w_tdi_out_nxt   = r_tdi_out;
    w_rsp_valid_nxt = r_rsp_valid;
    w_rsp_tdo_nxt   = r_rsp_tdo;
    w_ctrl_nxt      = CTRL_WE ? CTRL_DATA : r_ctrl;
    w_abort_nxt     = CTRL_WE ? 1'b0 : r_abort;
    w_oe_n_nxt      = ~w_run_ok;
    // Ready lags entry into IDLE by one cycle and drops on the accepting edge
    w_ready_nxt     = (r_state == S_IDLE) && !r_rsp_valid && !w_accept;

    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_tdi_nxt      = CMD_TDI;
          w_len_nxt      = CMD_LEN;
          w_tms_last_nxt = CMD_TMS_LAST;
          w_read_nxt     = CMD_READ;
          w_idx_nxt      = 3'd0;
          w_cap_nxt      = 8'h00;
          w_cnt_nxt      = 8'h00;
          if (w_run_ok) begin
            w_state_nxt   = S_LOW;
            w_tck_nxt     = 1'b0;
            w_tdi_out_nxt = CMD_TDI[0];
            w_tms_nxt     = CMD_TMS_LAST & (CMD_LEN == 3'd0);
          end else begin
            w_abort_nxt = 1'b1;
          end
        end
      end
      S_LOW: begin
        if (!w_run_ok) begin
          w_state_nxt = S_IDLE;
          w_tck_nxt   = 1'b0;
          w_abort_nxt = 1'b1;
        end else if (r_cnt == LP_HALF_M1) begin
          w_state_nxt      = S_HIGH;
          w_cnt_nxt        = 8'h00;
          w_tck_nxt        = 1'b1;
          w_cap_nxt[r_idx] = r_tdo_s[1];
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      S_HIGH: begin
        if (!w_run_ok) begin
          w_state_nxt = S_IDLE;
          w_tck_nxt   = 1'b0;
          w_abort_nxt = 1'b1;
        end else if (r_cnt == LP_HALF_M1) begin
          w_cnt_nxt = 8'h00;
          w_tck_nxt = 1'b0;
          if (r_idx < r_len) begin
            w_idx_nxt     = w_idx_inc;
            w_state_nxt   = S_LOW;
            w_tdi_out_nxt = r_tdi[w_idx_inc];
            w_tms_nxt     = r_tms_last & (w_idx_inc == r_len);
          end else if (r_read) begin
            w_state_nxt     = S_RESP;
            w_rsp_valid_nxt = 1'b1;
            w_rsp_tdo_nxt   = r_cap;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      S_RESP: begin
        if (RSP_READY) begin
          w_rsp_valid_nxt = 1'b0;
          w_state_nxt     = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state     <= S_IDLE;
      r_cnt       <= 8'h00;
      r_idx       <= 3'd0;
      r_tdi       <= 8'h00;
      r_len       <= 3'd0;
      r_tms_last  <= 1'b0;
      r_read      <= 1'b0;
      r_cap       <= 8'h00;
      r_tck       <= 1'b0;
      r_tms       <= 1'b1;
      r_tdi_out   <= 1'b0;
      r_oe_n      <= 1'b1;
      r_ready     <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_tdo   <= 8'h00;
      r_ctrl      <= 3'b000;
      r_abort     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_idx       <= w_idx_nxt;
      r_tdi       <= w_tdi_nxt;
      r_len       <= w_len_nxt;
      r_tms_last  <= w_tms_last_nxt;
      r_read      <= w_read_nxt;
      r_cap       <= w_cap_nxt;
      r_tck       <= w_tck_nxt;
      r_tms       <= w_tms_nxt;
      r_tdi_out   <= w_tdi_out_nxt;
      r_oe_n      <= w_oe_n_nxt;
      r_ready     <= w_ready_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_tdo   <= w_rsp_tdo_nxt;
      r_ctrl      <= w_ctrl_nxt;
      r_abort     <= w_abort_nxt;
    end
  end

  // TRST/SRST are open-drain: drive low when asserted, otherwise release high
  assign TRST_N_OE_N = ~r_ctrl[1];
  assign TRST_N_OUT  = ~r_ctrl[1];
  assign SRST_N_OE_N = ~r_ctrl[2];
  assign SRST_N_OUT  = ~r_ctrl[2];

  assign CMD_READY = r_ready;
  assign RSP_VALID = r_rsp_valid;
  assign RSP_TDO   = r_rsp_tdo;
  assign STAT      = {r_abort, ~r_srst_s[1], w_vref_ok};
  assign TCK_OUT   = r_tck;
  assign TMS_OUT   = r_tms;
  assign TDI_OUT   = r_tdi_out;
  assign JTAG_OE_N = r_oe_n;

endmodule

// File: tb/tb_jtag_shift_engine.sv
// Self-checking bench for jtag_shift_engine: directed scenarios plus random
// shifts compared against a bit-level reference of what the wires should show.
module tb_jtag_shift_engine;

  localparam int HALF = 4;

  logic       CLK = 1'b0;
  logic       RST_N, CMD_VALID, CMD_READY;
  logic [7:0] CMD_TDI;
  logic [2:0] CMD_LEN;
  logic       CMD_TMS_LAST, CMD_READ, RSP_VALID, RSP_READY;
  logic [7:0] RSP_TDO;
  logic       CTRL_WE;
  logic [2:0] CTRL_DATA, STAT;
  logic       TCK_OUT, TMS_OUT, TDI_OUT, JTAG_OE_N;
  logic       TRST_N_OE_N, TRST_N_OUT, SRST_N_OE_N, SRST_N_OUT;
  logic       TDO_IN, SRST_N_IN, VREF_N_IN;
  logic       tdoInvert;

  int checks = 0;
  int failures = 0;

  jtag_shift_engine #(.HALF(HALF)) dut (
    .CLK(CLK), .RST_N(RST_N), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
    .CMD_TDI(CMD_TDI), .CMD_LEN(CMD_LEN), .CMD_TMS_LAST(CMD_TMS_LAST),
    .CMD_READ(CMD_READ), .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY),
    .RSP_TDO(RSP_TDO), .CTRL_WE(CTRL_WE), .CTRL_DATA(CTRL_DATA), .STAT(STAT),
    .TCK_OUT(TCK_OUT), .TMS_OUT(TMS_OUT), .TDI_OUT(TDI_OUT), .JTAG_OE_N(JTAG_OE_N),
    .TRST_N_OE_N(TRST_N_OE_N), .TRST_N_OUT(TRST_N_OUT),
    .SRST_N_OE_N(SRST_N_OE_N), .SRST_N_OUT(SRST_N_OUT),
    .TDO_IN(TDO_IN), .SRST_N_IN(SRST_N_IN), .VREF_N_IN(VREF_N_IN)
  );

  always #5 CLK = ~CLK;

  // Target model: TDO echoes TDI, optionally inverted
  assign TDO_IN = TDI_OUT ^ tdoInvert;

  function automatic logic [7:0] lenMask(input logic [2:0] len);
    int m;
    m = (1 << (int'(len) + 1)) - 1;
    return 8'(m);
  endfunction

  function automatic int expReadyDelay(input logic [2:0] len, input logic rd, input int hold);
    int bits;
    bits = int'(len) + 1;
    return rd ? bits * 2 * HALF + hold + 2 : bits * 2 * HALF + 1;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic writeCtrl(input logic [2:0] d);
    CTRL_DATA = d;
    CTRL_WE = 1'b1;
    tick();
    CTRL_WE = 1'b0;
  endtask

  task automatic waitReady();
    int n;
    n = 0;
    while (CMD_READY !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
    checks++;
    if (CMD_READY !== 1'b1) begin
      failures++;
      $display("[TB] FAIL wait_ready: CMD_READY=%b required 1 within 300 cycles", CMD_READY);
    end
  endtask

  task automatic startCmd(input logic [7:0] tdi, input logic [2:0] len,
                          input logic tms, input logic rd);
    waitReady();
    CMD_TDI = tdi;
    CMD_LEN = len;
    CMD_TMS_LAST = tms;
    CMD_READ = rd;
    CMD_VALID = 1'b1;
    tick();
    CMD_VALID = 1'b0;
  endtask

  task automatic waitPulses(input int n);
    int seen, c;
    logic prevTck;
    seen = 0;
    c = 0;
    prevTck = TCK_OUT;
    while (seen < n && c < 400) begin
      tick();
      c++;
      if (TCK_OUT === 1'b1 && prevTck === 1'b0) seen++;
      prevTck = TCK_OUT;
    end
    checks++;
    if (seen != n) begin
      failures++;
      $display("[TB] FAIL wait_pulses: saw %0d TCK pulses, required %0d", seen, n);
    end
  endtask

  // Runs one command to completion and reports what appeared on the wires
  task automatic doShift(input logic [7:0] tdi, input logic [2:0] len, input logic tms,
                         input logic rd, input int hold,
                         output logic [7:0] tdiSeq, output logic [7:0] tmsSeq,
                         output int pulses, output int highCycles, output int readyDelay,
                         output logic sawRsp, output logic [7:0] rspVal,
                         output logic unstable, output logic readyDuringRsp,
                         output logic postHsValid);
    int c, rspCycle;
    logic prevTck, done;
    tdiSeq = 8'h00; tmsSeq = 8'h00; pulses = 0; highCycles = 0; readyDelay = -1;
    sawRsp = 1'b0; rspVal = 8'h00; unstable = 1'b0; readyDuringRsp = 1'b0;
    postHsValid = 1'b0; rspCycle = 0; done = 1'b0; c = 0;
    startCmd(tdi, len, tms, rd);
    prevTck = TCK_OUT;
    while (!done && c < 600) begin
      tick();
      c++;
      if (TCK_OUT === 1'b1 && prevTck === 1'b0) begin
        if (pulses < 8) begin
          tdiSeq[pulses] = TDI_OUT;
          tmsSeq[pulses] = TMS_OUT;
        end
        pulses++;
      end
      if (TCK_OUT === 1'b1) highCycles++;
      prevTck = TCK_OUT;
      if (RSP_READY === 1'b1) begin
        RSP_READY = 1'b0;
        postHsValid = RSP_VALID;
      end else if (RSP_VALID === 1'b1) begin
        if (!sawRsp) begin
          sawRsp = 1'b1;
          rspVal = RSP_TDO;
          rspCycle = c;
        end else if (RSP_TDO !== rspVal) begin
          unstable = 1'b1;
        end
        if (CMD_READY === 1'b1) readyDuringRsp = 1'b1;
        if (c - rspCycle >= hold) RSP_READY = 1'b1;
      end
      if (CMD_READY === 1'b1) begin
        done = 1'b1;
        readyDelay = c;
      end
    end
  endtask

  task automatic test_reset();
    logic [10:0] obs;
    RST_N = 1'b0;
    repeat (3) tick();
    obs = {TCK_OUT, TMS_OUT, TDI_OUT, JTAG_OE_N, TRST_N_OE_N, TRST_N_OUT,
           SRST_N_OE_N, SRST_N_OUT, CMD_READY, RSP_VALID, STAT[2]};
    checks++;
    if (obs !== 11'b01011111000) begin
      failures++;
      $display("[TB] FAIL reset_outputs: got %b required %b", obs, 11'b01011111000);
    end
    checks++;
    if (RSP_TDO !== 8'h00) begin
      failures++;
      $display("[TB] FAIL reset_rsp_tdo: got %h required 00", RSP_TDO);
    end
    RST_N = 1'b1;
    tick();
    checks++;
    if (CMD_READY !== 1'b1) begin
      failures++;
      $display("[TB] FAIL ready_after_reset: got %b required 1", CMD_READY);
    end
    writeCtrl(3'b001);
    repeat (3) tick();
    checks++;
    if (JTAG_OE_N !== 1'b0) begin
      failures++;
      $display("[TB] FAIL oe_enable: JTAG_OE_N=%b required 0", JTAG_OE_N);
    end
    checks++;
    if (STAT[1:0] !== 2'b01) begin
      failures++;
      $display("[TB] FAIL stat_idle: STAT[1:0]=%b required 01", STAT[1:0]);
    end
  endtask

  task automatic test_a5_loopback();
    logic [7:0] tdiSeq, tmsSeq, rspVal;
    int pulses, highCycles, readyDelay;
    logic sawRsp, unstable, rdy, postHs;
    tdoInvert = 1'b0;
    doShift(8'hA5, 3'd7, 1'b0, 1'b1, 0, tdiSeq, tmsSeq, pulses, highCycles, readyDelay,
            sawRsp, rspVal, unstable, rdy, postHs);
    checks++;
    if (tdiSeq !== 8'hA5) begin
      failures++;
      $display("[TB] FAIL a5_tdi_seq: got %h required a5", tdiSeq);
    end
    checks++;
    if (pulses != 8 || highCycles != 8 * HALF) begin
      failures++;
      $display("[TB] FAIL a5_tck: pulses=%0d high=%0d required 8 and %0d", pulses, highCycles, 8 * HALF);
    end
    checks++;
    if (!sawRsp || rspVal !== 8'hA5) begin
      failures++;
      $display("[TB] FAIL a5_rsp: valid=%b tdo=%h required 1 and a5", sawRsp, rspVal);
    end
    checks++;
    if (readyDelay != expReadyDelay(3'd7, 1'b1, 0)) begin
      failures++;
      $display("[TB] FAIL a5_ready_delay: got %0d required %0d", readyDelay, expReadyDelay(3'd7, 1'b1, 0));
    end
  endtask

  task automatic test_tms();
    logic [7:0] tdiSeq, tmsSeq, rspVal;
    int pulses, highCycles, readyDelay;
    logic sawRsp, unstable, rdy, postHs;
    doShift(8'($urandom), 3'd2, 1'b1, 1'b0, 0, tdiSeq, tmsSeq, pulses, highCycles,
            readyDelay, sawRsp, rspVal, unstable, rdy, postHs);
    checks++;
    if (tmsSeq !== 8'b0000_0100) begin
      failures++;
      $display("[TB] FAIL tms_pattern: got %b required 00000100", tmsSeq);
    end
    checks++;
    if (sawRsp !== 1'b0) begin
      failures++;
      $display("[TB] FAIL tms_no_rsp: RSP_VALID seen=%b required 0", sawRsp);
    end
    checks++;
    if (readyDelay != 3 * 2 * HALF + 1) begin
      failures++;
      $display("[TB] FAIL tms_ready_delay: got %0d required %0d", readyDelay, 3 * 2 * HALF + 1);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] tdi, tdiSeq, tmsSeq, rspVal;
    int pulses, highCycles, readyDelay;
    logic sawRsp, unstable, rdy, postHs;
    tdi = 8'($urandom);
    doShift(tdi, 3'd5, 1'b0, 1'b1, 20, tdiSeq, tmsSeq, pulses, highCycles, readyDelay,
            sawRsp, rspVal, unstable, rdy, postHs);
    checks++;
    if (rspVal !== (tdi & 8'h3F) || unstable !== 1'b0) begin
      failures++;
      $display("[TB] FAIL bp_rsp_stable: tdo=%h unstable=%b required %h and 0", rspVal, unstable, tdi & 8'h3F);
    end
    checks++;
    if (rdy !== 1'b0 || postHs !== 1'b0) begin
      failures++;
      $display("[TB] FAIL bp_handshake: ready_in_rsp=%b valid_after=%b required 0 and 0", rdy, postHs);
    end
    checks++;
    if (readyDelay != expReadyDelay(3'd5, 1'b1, 20)) begin
      failures++;
      $display("[TB] FAIL bp_ready_delay: got %0d required %0d", readyDelay, expReadyDelay(3'd5, 1'b1, 20));
    end
  endtask

  task automatic test_random();
    logic [7:0] tdi, tdiSeq, tmsSeq, rspVal, expRsp, expTms;
    logic [2:0] len;
    logic tms, rd, sawRsp, unstable, rdy, postHs;
    int hold, pulses, highCycles, readyDelay;
    for (int it = 0; it < 10; it++) begin
      tdi = 8'($urandom);
      len = 3'($urandom_range(0, 7));
      tms = 1'($urandom_range(0, 1));
      rd = 1'($urandom_range(0, 1));
      hold = $urandom_range(0, 3);
      tdoInvert = 1'($urandom_range(0, 1));
      expRsp = (tdi ^ {8{tdoInvert}}) & lenMask(len);
      expTms = tms ? 8'(1 << int'(len)) : 8'h00;
      doShift(tdi, len, tms, rd, hold, tdiSeq, tmsSeq, pulses, highCycles, readyDelay,
              sawRsp, rspVal, unstable, rdy, postHs);
      checks++;
      if (tdiSeq !== (tdi & lenMask(len)) || tmsSeq !== expTms) begin
        failures++;
        $display("[TB] FAIL rand_bits[%0d]: tdi=%h tms=%b required %h and %b", it, tdiSeq, tmsSeq, tdi & lenMask(len), expTms);
      end
      checks++;
      if (pulses != int'(len) + 1 || highCycles != (int'(len) + 1) * HALF) begin
        failures++;
        $display("[TB] FAIL rand_tck[%0d]: pulses=%0d high=%0d required %0d and %0d", it, pulses, highCycles, int'(len) + 1, (int'(len) + 1) * HALF);
      end
      checks++;
      if (readyDelay != expReadyDelay(len, rd, hold)) begin
        failures++;
        $display("[TB] FAIL rand_ready_delay[%0d]: got %0d required %0d", it, readyDelay, expReadyDelay(len, rd, hold));
      end
      checks++;
      if (sawRsp !== rd || (rd && rspVal !== expRsp)) begin
        failures++;
        $display("[TB] FAIL rand_rsp[%0d]: valid=%b tdo=%h required %b and %h", it, sawRsp, rspVal, rd, expRsp);
      end
      checks++;
      if (TCK_OUT !== 1'b0 || TDI_OUT !== tdi[len] || TMS_OUT !== tms) begin
        failures++;
        $display("[TB] FAIL rand_idle_hold[%0d]: tck=%b tdi=%b tms=%b required 0 %b %b", it, TCK_OUT, TDI_OUT, TMS_OUT, tdi[len], tms);
      end
    end
    tdoInvert = 1'b0;
  endtask

  task automatic test_vref_loss();
    logic sawRsp;
    startCmd(8'h3C, 3'd7, 1'b0, 1'b1);
    waitPulses(4);
    VREF_N_IN = 1'b1;
    repeat (3) tick();
    checks++;
    if (JTAG_OE_N !== 1'b1 || TCK_OUT !== 1'b0 || STAT[2] !== 1'b1) begin
      failures++;
      $display("[TB] FAIL vref_abort: oe_n=%b tck=%b stat2=%b required 1 0 1", JTAG_OE_N, TCK_OUT, STAT[2]);
    end
    sawRsp = 1'b0;
    repeat (80) begin
      tick();
      if (RSP_VALID === 1'b1) sawRsp = 1'b1;
    end
    checks++;
    if (sawRsp !== 1'b0 || CMD_READY !== 1'b1) begin
      failures++;
      $display("[TB] FAIL vref_no_rsp: rsp_seen=%b ready=%b required 0 and 1", sawRsp, CMD_READY);
    end
    writeCtrl(3'b001);
    checks++;
    if (STAT[2] !== 1'b0) begin
      failures++;
      $display("[TB] FAIL vref_sticky_clear: stat2=%b required 0", STAT[2]);
    end
    VREF_N_IN = 1'b0;
    repeat (3) tick();
    checks++;
    if (JTAG_OE_N !== 1'b0 || STAT[0] !== 1'b1) begin
      failures++;
      $display("[TB] FAIL vref_restore: oe_n=%b stat0=%b required 0 and 1", JTAG_OE_N, STAT[0]);
    end
  endtask

  task automatic test_disabled_abort();
    logic activity;
    writeCtrl(3'b000);
    startCmd(8'hFF, 3'd3, 1'b0, 1'b1);
    checks++;
    if (STAT[2] !== 1'b1) begin
      failures++;
      $display("[TB] FAIL dis_sticky: stat2=%b required 1", STAT[2]);
    end
    tick();
    checks++;
    if (CMD_READY !== 1'b1) begin
      failures++;
      $display("[TB] FAIL dis_ready: CMD_READY=%b required 1", CMD_READY);
    end
    activity = 1'b0;
    repeat (12) begin
      tick();
      if (TCK_OUT === 1'b1 || RSP_VALID === 1'b1) activity = 1'b1;
    end
    checks++;
    if (activity !== 1'b0) begin
      failures++;
      $display("[TB] FAIL dis_no_shift: activity=%b required 0", activity);
    end
    writeCtrl(3'b001);
    checks++;
    if (STAT[2] !== 1'b0) begin
      failures++;
      $display("[TB] FAIL dis_sticky_clear: stat2=%b required 0", STAT[2]);
    end
  endtask

  task automatic test_reset_lines();
    writeCtrl(3'b111);
    checks++;
    if ({TRST_N_OE_N, TRST_N_OUT, SRST_N_OE_N, SRST_N_OUT} !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL rst_lines_on: got %b required 0000", {TRST_N_OE_N, TRST_N_OUT, SRST_N_OE_N, SRST_N_OUT});
    end
    SRST_N_IN = 1'b0;
    repeat (3) tick();
    checks++;
    if (STAT[1] !== 1'b1) begin
      failures++;
      $display("[TB] FAIL srst_seen: stat1=%b required 1", STAT[1]);
    end
    SRST_N_IN = 1'b1;
    writeCtrl(3'b001);
    repeat (2) tick();
    checks++;
    if ({TRST_N_OE_N, TRST_N_OUT, SRST_N_OE_N, SRST_N_OUT, STAT[1]} !== 5'b11110) begin
      failures++;
      $display("[TB] FAIL rst_lines_off: got %b required 11110", {TRST_N_OE_N, TRST_N_OUT, SRST_N_OE_N, SRST_N_OUT, STAT[1]});
    end
  endtask

  task automatic test_reset_mid_op();
    logic [10:0] obs;
    logic activity;
    startCmd(8'($urandom), 3'd7, 1'b0, 1'b1);
    waitPulses(5);
    RST_N = 1'b0;
    tick();
    obs = {TCK_OUT, TMS_OUT, TDI_OUT, JTAG_OE_N, TRST_N_OE_N, TRST_N_OUT,
           SRST_N_OE_N, SRST_N_OUT, CMD_READY, RSP_VALID, STAT[2]};
    checks++;
    if (obs !== 11'b01011111000 || RSP_TDO !== 8'h00) begin
      failures++;
      $display("[TB] FAIL mid_reset: got %b tdo=%h required 01011111000 and 00", obs, RSP_TDO);
    end
    RST_N = 1'b1;
    tick();
    checks++;
    if (CMD_READY !== 1'b1) begin
      failures++;
      $display("[TB] FAIL mid_reset_ready: got %b required 1", CMD_READY);
    end
    activity = 1'b0;
    repeat (100) begin
      tick();
      if (RSP_VALID === 1'b1 || TCK_OUT === 1'b1) activity = 1'b1;
    end
    checks++;
    if (activity !== 1'b0) begin
      failures++;
      $display("[TB] FAIL mid_reset_quiet: activity=%b required 0", activity);
    end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    RST_N = 1'b0;
    CMD_VALID = 1'b0;
    CMD_TDI = 8'h00;
    CMD_LEN = 3'd0;
    CMD_TMS_LAST = 1'b0;
    CMD_READ = 1'b0;
    RSP_READY = 1'b0;
    CTRL_WE = 1'b0;
    CTRL_DATA = 3'b000;
    SRST_N_IN = 1'b1;
    VREF_N_IN = 1'b0;
    tdoInvert = 1'b0;
    test_reset();
    test_a5_loopback();
    test_tms();
    test_backpressure();
    test_random();
    test_vref_loss();
    test_disabled_abort();
    test_reset_lines();
    test_reset_mid_op();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
